// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: register address, data word and buffered result entry.
package wb_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_addr_t rd;
        word_t     wd;
    } wb_entry_t;

    localparam reg_addr_t REG_X0   = 5'd0;
    localparam int        NUM_REGS = 32;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; a push is visible at head the next cycle.
// Backpressure: push is ignored while full, pop is ignored while empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_dat,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    wb_entry_t        mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port: primary wins combinationally, buffered secondary results fill idle slots (>=1 cycle).
// Backpressure: s_ready drops when the FIFO is full; iss_ready drops on a busy rd. WB_CONFLICT_CNT_EN adds conflict_cnt.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_we,
    input  logic [4:0]  p_rd,
    input  logic [31:0] p_wd,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_ready,
    input  logic        s_valid,
    input  logic [4:0]  s_rd,
    input  logic [31:0] s_wd,
    output logic        s_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        hz_stall,
    output logic        wb_we,
    output logic [4:0]  wb_ad,
    output logic [31:0] wb_wd,
    output logic [31:0] busy_vec
`ifdef WB_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    wb_entry_t           push_dat;
    wb_entry_t           head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                p_win;
    logic                push;
    logic                pop;
    logic                iss_set;

    // A primary write to x0 is a no-op and must not steal the slot.
    assign p_win    = p_we && (p_rd != REG_X0);
    assign pop      = !rst && !p_win && !fifo_empty;
    assign push     = s_valid && s_ready && (s_rd != REG_X0);
    assign iss_set  = iss_valid && iss_ready && (iss_rd != REG_X0);
    assign push_dat = '{rd: s_rd, wd: s_wd};

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        wb_we = 1'b0;
        wb_ad = REG_X0;
        wb_wd = '0;
        if (!rst) begin
            if (p_win) begin
                wb_we = 1'b1;
                wb_ad = p_rd;
                wb_wd = p_wd;
            end else if (!fifo_empty) begin
                wb_we = 1'b1;
                wb_ad = head.rd;
                wb_wd = head.wd;
            end
        end
    end

    always_comb begin
        s_ready   = !rst && !fifo_full;
        iss_ready = !rst && ((iss_rd == REG_X0) || !busy[iss_rd]);
        hz_stall  = ((rs1 != REG_X0) && busy[rs1]) || ((rs2 != REG_X0) && busy[rs2]);
        busy_vec  = busy;
    end

    // Set is applied after clear so a same-cycle collision leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (pop)     busy_nxt = busy_nxt & ~reg_onehot(head.rd);
        if (iss_set) busy_nxt = busy_nxt | reg_onehot(iss_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

`ifdef WB_CONFLICT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (p_win && !fifo_empty && (conflict_cnt != {CNT_W{1'b1}}))
            conflict_cnt <= conflict_cnt + 1'b1;
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (FIFO_DEPTH >= 2 && (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0 && CNT_W >= 1)
                else $error("wb_arbiter: bad parameters FIFO_DEPTH=%0d CNT_W=%0d", FIFO_DEPTH, CNT_W);
            assert (!(iss_valid && !iss_ready))
                else $error("wb_arbiter: issue to busy rd %0d", iss_rd);
            assert (!(s_valid && (s_rd != REG_X0) && !busy[s_rd]))
                else $error("wb_arbiter: secondary result for idle rd %0d", s_rd);
            assert (!(p_win && busy[p_rd]))
                else $error("wb_arbiter: primary WAW on busy rd %0d", p_rd);
        end
    end
`endif

endmodule
